// File: rtl/mmu_config_unit_ctrl_if.sv
// Peripheral-bus port bundle for the MMU configuration unit.
// The slave side is the config unit; the master side is the peripheral interconnect.
interface mmu_config_unit_ctrl_if #(
    parameter int unsigned ID_WIDTH = 5
);
    logic                req_i;
    logic [31:0]         add_i;
    logic                wen_i;
    logic [31:0]         wdata_i;
    logic [3:0]          be_i;
    logic [ID_WIDTH-1:0] id_i;
    logic                gnt_o;
    logic                r_valid_o;
    logic [31:0]         r_rdata_o;
    logic                r_opc_o;
    logic [ID_WIDTH-1:0] r_id_o;

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i, id_i,
        output gnt_o, r_valid_o, r_rdata_o, r_opc_o, r_id_o
    );

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i, id_i,
        input  gnt_o, r_valid_o, r_rdata_o, r_opc_o, r_id_o
    );
endinterface

// File: rtl/mmu_config_unit_ctrl.sv
// MMU sequential-section config: shadow registers plus a commit sequence that
// quiesces TCDM traffic and swaps both active sizes in a single edge.
module mmu_config_unit_ctrl #(
    parameter int unsigned ID_WIDTH      = 5,
    parameter logic [3:0]  SRAM_MAX_SIZE = 4'd11,
    parameter logic [3:0]  SCM_MAX_SIZE  = 4'd8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    mmu_config_unit_ctrl_if.slave       bus,
    input  logic                        tcdm_idle_i,
    output logic                        tcdm_block_o,
    output logic [3:0]                  mmu_sram_seqsec_size_o,
    output logic [3:0]                  mmu_scm_seqsec_size_o
);
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_APPLY} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_block;
    logic [3:0]          r_sram_sh, r_scm_sh, r_sram_act, r_scm_act;
    logic                r_valid, r_opc;
    logic [31:0]         r_rdata;
    logic [ID_WIDTH-1:0] r_id;

    logic [1:0]  w_addr;
    logic        w_write, w_wr_stall, w_gnt, w_wr_en, w_commit;
    logic [3:0]  w_sram_sat, w_scm_sat;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_addr  = bus.add_i[3:2];
    assign w_write = bus.req_i & ~bus.wen_i;
    // Config writes wait while a commit is in flight so the shadows stay frozen;
    // the ACTIVE slot is exempt since writing it only reports an error.
    assign w_wr_stall = w_write & (w_addr != 2'd3) & (r_state != S_IDLE);
    assign w_gnt      = bus.req_i & ~w_wr_stall;
    assign w_wr_en    = w_gnt & ~bus.wen_i & bus.be_i[0];
    assign w_commit   = w_wr_en & (w_addr == 2'd2) & bus.wdata_i[0];

    assign w_sram_sat = (bus.wdata_i[3:0] > SRAM_MAX_SIZE) ? SRAM_MAX_SIZE : bus.wdata_i[3:0];
    assign w_scm_sat  = (bus.wdata_i[3:0] > SCM_MAX_SIZE)  ? SCM_MAX_SIZE  : bus.wdata_i[3:0];

    assign w_unused = ^{bus.add_i[31:4], bus.add_i[1:0], bus.wdata_i[31:4], bus.be_i[3:1]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_commit) w_state_nxt = S_DRAIN;
            S_DRAIN: if (tcdm_idle_i) w_state_nxt = S_APPLY;
            S_APPLY: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            2'd0: w_rdata = {28'd0, r_sram_sh};
            2'd1: w_rdata = {28'd0, r_scm_sh};
            2'd2: w_rdata = {30'd0, (r_state != S_IDLE), 1'b0};
            2'd3: w_rdata = {20'd0, r_scm_act, 4'd0, r_sram_act};
            default: w_rdata = 32'd0;
        endcase
    end

    // Block is registered off the next state so it falls exactly when the new sizes land.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_block    <= 1'b0;
            r_sram_act <= 4'd0;
            r_scm_act  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_block <= (w_state_nxt != S_IDLE);
            if (r_state == S_APPLY) begin
                r_sram_act <= r_sram_sh;
                r_scm_act  <= r_scm_sh;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sram_sh <= 4'd0;
            r_scm_sh  <= 4'd0;
        end else if (w_wr_en) begin
            if (w_addr == 2'd0) r_sram_sh <= w_sram_sat;
            if (w_addr == 2'd1) r_scm_sh  <= w_scm_sat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_opc   <= 1'b0;
            r_rdata <= 32'd0;
            r_id    <= '0;
        end else begin
            r_valid <= w_gnt;
            if (w_gnt) begin
                r_id    <= bus.id_i;
                r_opc   <= ~bus.wen_i & (w_addr == 2'd3);
                r_rdata <= bus.wen_i ? w_rdata : 32'd0;
            end
        end
    end

    assign bus.gnt_o              = w_gnt;
    assign bus.r_valid_o          = r_valid;
    assign bus.r_opc_o            = r_opc;
    assign bus.r_rdata_o          = r_rdata;
    assign bus.r_id_o             = r_id;
    assign tcdm_block_o           = r_block;
    assign mmu_sram_seqsec_size_o = r_sram_act;
    assign mmu_scm_seqsec_size_o  = r_scm_act;
endmodule
